// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, opcodes and arbiter FSM encoding
package alu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 3;

    localparam logic [2:0] ALU_ADD      = 3'b000;
    localparam logic [2:0] ALU_SUB      = 3'b001;
    localparam logic [2:0] ALU_AND      = 3'b010;
    localparam logic [2:0] ALU_OR       = 3'b011;
    localparam logic [2:0] ALU_RSVD_MIN = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr and wraps
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] pos;
    logic            found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            pos = sum[ID_W-1:0];
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - shares one combinational ALU among NUM_REQ requesters
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_opperand_1,
    input  logic [NUM_REQ*DATA_W-1:0] req_opperand_2,
    input  logic [NUM_REQ*OP_W-1:0]   req_opcode,
    output logic [DATA_W-1:0]         alu_opperand_1,
    output logic [DATA_W-1:0]         alu_opperand_2,
    output logic [OP_W-1:0]           alu_opcode,
    input  logic [DATA_W-1:0]         alu_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_err,
    output logic                      busy
);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   idx_q;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]   grant_idx;
    logic              accept;
    logic              issue;
    logic              rsp_done;
    logic              rsvd_op;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Grant is only exposed while idle and out of reset, so ready stays one-hot or zero.
    assign req_ready = (rst_n && state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);
    assign rsvd_op   = (alu_opcode >= OP_W'(ALU_RSVD_MIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (|grant) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                issue      = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr            <= '0;
            idx_q          <= '0;
            alu_opperand_1 <= '0;
            alu_opperand_2 <= '0;
            alu_opcode     <= '0;
        end else if (accept) begin
            alu_opperand_1 <= req_opperand_1[grant_idx*DATA_W +: DATA_W];
            alu_opperand_2 <= req_opperand_2[grant_idx*DATA_W +: DATA_W];
            alu_opcode     <= req_opcode[grant_idx*OP_W +: OP_W];
            idx_q          <= grant_idx;
            ptr            <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    // Response fields are captured once in ISSUE and then frozen until the consumer accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
        end else if (issue) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rsvd_op ? '0 : alu_out;
            rsp_id    <= idx_q;
            rsp_err   <= rsvd_op;
        end else if (rsp_done) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Shares the single combinational 8-bit ALU among NUM_REQ independent requesters. Each requester uses a valid/ready handshake. The block arbitrates round-robin, latches the winner's operands and opcode, and drives them to the ALU. It then captures alu_out and returns a response tagged with the requester ID. It sits between the requesting engines and the ALU instance at the datapath top level, and allows one operation in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, operand/result width; must match the ALU
OP_W, 3, opcode width; must match the ALU
ID_W, $clog2(NUM_REQ), width of the response tag

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_opperand_1  in  NUM_REQ*DATA_W  flattened operand 1; slice i belongs to requester i
req_opperand_2  in  NUM_REQ*DATA_W  flattened operand 2
req_opcode  in  NUM_REQ*OP_W  flattened opcode
alu_opperand_1  out  DATA_W  to ALU opperand_1
alu_opperand_2  out  DATA_W  to ALU opperand_2
alu_opcode  out  OP_W  to ALU opcode
alu_out  in  DATA_W  from ALU alu_out (combinational)
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer accept
rsp_data  out  DATA_W  captured result
rsp_id  out  ID_W  index of the requester served
rsp_err  out  1  reserved opcode was issued
busy  out  1  high when state is not IDLE

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - State IDLE, round-robin pointer 0.
  - req_ready, alu_opperand_1, alu_opperand_2, alu_opcode, rsp_valid, rsp_data, rsp_id, rsp_err and busy are all 0.
  - req_ready is forced 0 while rst_n is low.
- FSM: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - Grant goes to the first requester with req_valid=1, searching from the pointer upward and wrapping at NUM_REQ-1 to 0.
  - req_ready[grant]=1 combinationally; all other bits are 0.
  - If no requester is valid, req_ready is 0 and the block stays in IDLE.
  - On the accept edge, the block latches the granted slices into the alu_* registers and latches the winner's index.
  - Pointer <= (grant+1) mod NUM_REQ. Next state is ISSUE.
- ISSUE (one cycle):
  - alu_* outputs hold the latched values.
  - At the edge: rsp_data <= alu_out, rsp_id <= latched index, rsp_err <= (alu_opcode >= 3'b100), rsp_valid <= 1. Next state is RESP.
  - For a reserved opcode, rsp_data <= 0 regardless of alu_out.
- RESP:
  - rsp_valid, rsp_data, rsp_id and rsp_err are held stable until rsp_ready=1.
  - On that edge: rsp_valid <= 0, next state IDLE.
  - No new accept occurs in the RESP cycle. Minimum spacing is 3 cycles per operation.
- Latency: accept edge at T gives rsp_valid high from T+2.
- alu_* outputs are registered and keep the last value after completion. This keeps the ALU inputs glitch-free.
- Requesters must hold valid and payload stable until ready. A requester that drops valid before grant is simply skipped.
- Reset asserted mid-operation: the operation is discarded and no response is ever produced; the pointer returns to 0.
- Opcodes 000 add, 001 sub, 010 and, 011 or. Arithmetic is modulo 2^DATA_W, with no carry or flag output.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W and OP_W defaults.
  - Opcode constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR.
  - ALU_RSVD_MIN = 3'b100.
  - FSM state encoding: IDLE, ISSUE, RESP.
- Sub-module rr_arbiter (NUM_REQ): takes req vector and pointer, returns one-hot grant and encoded index. It is combinational and reusable by other shared-resource controllers.

Test Plan:
1. Hold rst_n=0 with random req_valid -> req_ready=0, rsp_valid=0, alu_*=0, busy=0. Release -> idle.
2. Requester 0: add, 8'h03 + 8'h01 -> req_ready[0]=1 at cycle T, alu_opcode=000 at T+1, rsp_valid at T+2 with rsp_data=8'h04, rsp_id=0, rsp_err=0.
3. All four valid (add, sub 8'h01-8'h03, and 8'hF0&8'h3C, or 8'h0F|8'h30) with rsp_ready=1 -> served in order 0,1,2,3 with data 8'h04, 8'hFE, 8'h30, 8'h3F. Then requester 0 again; the pointer wraps.
4. rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable, req_ready=0 throughout. Release -> idle next cycle.
5. Requester 2 sends opcode 3'b101 -> rsp_err=1, rsp_data=8'h00, rsp_id=2.
6. rst_n pulsed low during ISSUE for requester 3 -> no rsp_valid afterwards. The next grant with all valid goes to requester 0.
